issue_scoreboard: RTL and testbench

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

---
 rtl/issue_scoreboard.sv | 130 +++++++++++++
 tb/tb_issue_scoreboard.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
// Register/functional-unit issue scoreboard: flags RAW, WAW and structural hazards
// for a decoded instruction and tracks in-flight destinations and busy units.
module issue_scoreboard #(
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned NUM_FU    = 4,
  parameter int unsigned WB_BYPASS = 1,
  parameter int unsigned CNT_W     = 16,
  localparam int unsigned REG_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int unsigned FU_W     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic                      issue_valid,
  input  logic [REG_W-1:0]          rs1,
  input  logic [REG_W-1:0]          rs2,
  input  logic                      rs1_used,
  input  logic                      rs2_used,
  input  logic [REG_W-1:0]          rd,
  input  logic                      rd_wen,
  input  logic [FU_W-1:0]           fu_sel,
  output logic                      issue_ready,
  output logic                      stall_raw,
  output logic                      stall_waw,
  output logic                      stall_struct,
  input  logic [NUM_FU-1:0]         fu_done,
  input  logic [NUM_FU-1:0]         wb_valid,
  input  logic [NUM_FU*REG_W-1:0]   wb_rd,
  input  logic                      flush,
  output logic [NUM_REGS-1:0]       pending_vec,
  output logic [NUM_FU-1:0]         fu_busy,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam logic [NUM_REGS-1:0] REG_ONE = NUM_REGS'(1);
  localparam logic [NUM_FU-1:0]   FU_ONE  = NUM_FU'(1);

  logic [NUM_REGS-1:0] r_pend;
  logic [NUM_FU-1:0]   r_busy;
  logic [CNT_W-1:0]    r_cnt;

  logic [NUM_REGS-1:0] w_wb_clr;
  logic [NUM_REGS-1:0] w_eff_pend;
  logic [NUM_FU-1:0]   w_eff_busy;
  logic                w_sel_busy;
  logic                w_raw;
  logic                w_waw;
  logic                w_struct;
  logic                w_issue;
  logic                w_cnt_inc;
  logic [NUM_REGS-1:0] w_pend_nxt;
  logic [NUM_FU-1:0]   w_busy_nxt;

  // Writeback clear mask and bypass-adjusted views of the tracked state
  always_comb begin
    w_wb_clr = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (wb_valid[i]) begin
        w_wb_clr = w_wb_clr | (REG_ONE << wb_rd[i*REG_W +: REG_W]);
      end
    end
    w_eff_pend = (WB_BYPASS != 0) ? (r_pend & ~w_wb_clr) : r_pend;
    w_eff_busy = (WB_BYPASS != 0) ? (r_busy & ~fu_done) : r_busy;
  end

  // An out-of-range unit index matches no unit and so reads as busy
  always_comb begin
    w_sel_busy = 1'b1;
    for (int i = 0; i < NUM_FU; i++) begin
      if (fu_sel == FU_W'(i)) begin
        w_sel_busy = w_eff_busy[i];
      end
    end
  end

  always_comb begin
    w_raw = 1'b0;
    w_waw = 1'b0;
    w_struct = 1'b0;
    w_issue = 1'b0;
    w_cnt_inc = 1'b0;
    if (issue_valid) begin
      w_raw = (rs1_used && (rs1 != '0) && (|(w_eff_pend & (REG_ONE << rs1)))) ||
              (rs2_used && (rs2 != '0) && (|(w_eff_pend & (REG_ONE << rs2))));
      w_waw = rd_wen && (rd != '0) && (|(w_eff_pend & (REG_ONE << rd)));
      w_struct = w_sel_busy;
      w_issue = !flush && !w_raw && !w_waw && !w_struct;
      w_cnt_inc = !w_issue && !flush && (r_cnt != '1);
    end
  end

  // Next state: a same-cycle set beats a clear of the same register/unit
  always_comb begin
    w_pend_nxt = r_pend & ~w_wb_clr;
    w_busy_nxt = r_busy & ~fu_done;
    if (w_issue) begin
      w_busy_nxt = w_busy_nxt | (FU_ONE << fu_sel);
      if (rd_wen && (rd != '0)) begin
        w_pend_nxt = w_pend_nxt | (REG_ONE << rd);
      end
    end
    if (flush) begin
      w_pend_nxt = '0;
      w_busy_nxt = '0;
    end
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_pend <= '0;
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      r_busy <= w_busy_nxt;
      if (w_cnt_inc) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign issue_ready  = w_issue;
  assign stall_raw    = w_raw;
  assign stall_waw    = w_waw;
  assign stall_struct = w_struct;
  assign pending_vec  = r_pend;
  assign fu_busy      = r_busy;
  assign stall_cnt    = r_cnt;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Scoreboard bench: two scoreboards (bypass on / 16-bit counter, bypass off / 4-bit
// counter) share one stimulus stream; a monitor checks both against queued expectations.
module tb_issue_scoreboard;

  typedef struct {
    logic        iv;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic        wen;
    logic [1:0]  fu;
    logic [3:0]  done;
    logic [3:0]  wbv;
    logic [19:0] wbrd;
    logic        fl;
  } stim_t;

  // comb fields are {issue_ready, stall_raw, stall_waw, stall_struct}
  typedef struct {
    string       name;
    logic [3:0]  comb_a;
    logic [3:0]  comb_b;
    logic [31:0] pend_a;
    logic [31:0] pend_b;
    logic [3:0]  busy_a;
    logic [3:0]  busy_b;
    logic [31:0] cnt_a;
    logic [31:0] cnt_b;
  } exp_t;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        issue_valid = 1'b0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic        rs1_used = 1'b0;
  logic        rs2_used = 1'b0;
  logic [4:0]  rd = '0;
  logic        rd_wen = 1'b0;
  logic [1:0]  fu_sel = '0;
  logic [3:0]  fu_done = '0;
  logic [3:0]  wb_valid = '0;
  logic [19:0] wb_rd = '0;
  logic        flush = 1'b0;

  logic        rdy_a, raw_a, waw_a, st_a;
  logic        rdy_b, raw_b, waw_b, st_b;
  logic [31:0] pend_a, pend_b;
  logic [3:0]  busy_a, busy_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 CLK = ~CLK;

  issue_scoreboard #(.NUM_REGS(32), .NUM_FU(4), .WB_BYPASS(1), .CNT_W(16)) dut_a (
    .CLK(CLK), .nRST(nRST), .issue_valid(issue_valid), .rs1(rs1), .rs2(rs2),
    .rs1_used(rs1_used), .rs2_used(rs2_used), .rd(rd), .rd_wen(rd_wen), .fu_sel(fu_sel),
    .issue_ready(rdy_a), .stall_raw(raw_a), .stall_waw(waw_a), .stall_struct(st_a),
    .fu_done(fu_done), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .pending_vec(pend_a), .fu_busy(busy_a), .stall_cnt(cnt_a)
  );

  issue_scoreboard #(.NUM_REGS(32), .NUM_FU(4), .WB_BYPASS(0), .CNT_W(4)) dut_b (
    .CLK(CLK), .nRST(nRST), .issue_valid(issue_valid), .rs1(rs1), .rs2(rs2),
    .rs1_used(rs1_used), .rs2_used(rs2_used), .rd(rd), .rd_wen(rd_wen), .fu_sel(fu_sel),
    .issue_ready(rdy_b), .stall_raw(raw_b), .stall_waw(waw_b), .stall_struct(st_b),
    .fu_done(fu_done), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .pending_vec(pend_b), .fu_busy(busy_b), .stall_cnt(cnt_b)
  );

  function automatic stim_t st(int iv, int r1, int u1, int r2, int u2, int d, int wen,
                               int fu, int done, int wbv, int wbrd, int fl);
    stim_t s;
    s.iv = 1'(iv);   s.rs1 = 5'(r1);  s.u1 = 1'(u1);  s.rs2 = 5'(r2);  s.u2 = 1'(u2);
    s.rd = 5'(d);    s.wen = 1'(wen); s.fu = 2'(fu);  s.done = 4'(done);
    s.wbv = 4'(wbv); s.wbrd = 20'(wbrd); s.fl = 1'(fl);
    return s;
  endfunction

  function automatic stim_t idle();
    return st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic stim_t fl_only();
    return st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endfunction

  task automatic apply(stim_t s);
    issue_valid = s.iv; rs1 = s.rs1; rs1_used = s.u1; rs2 = s.rs2; rs2_used = s.u2;
    rd = s.rd; rd_wen = s.wen; fu_sel = s.fu; fu_done = s.done;
    wb_valid = s.wbv; wb_rd = s.wbrd; flush = s.fl;
  endtask

  task automatic push_exp(string nm, int ca, int cb, int pa, int pb, int ba, int bb,
                          int cna, int cnb);
    exp_t e;
    e.name = nm;
    e.comb_a = 4'(ca);  e.comb_b = 4'(cb);
    e.pend_a = 32'(pa); e.pend_b = 32'(pb);
    e.busy_a = 4'(ba);  e.busy_b = 4'(bb);
    e.cnt_a = 32'(cna); e.cnt_b = 32'(cnb);
    q.push_back(e);
  endtask

  task automatic drive(string nm, stim_t s, int ca, int cb, int pa, int pb, int ba, int bb,
                       int cna, int cnb);
    @(posedge CLK);
    #1;
    apply(s);
    push_exp(nm, ca, cb, pa, pb, ba, bb, cna, cnb);
  endtask

  task automatic chk(string nm, string fld, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, fld, got, exp);
    end
  endtask

  // Monitor: compare the DUT outputs against the oldest expectation each negedge
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.name, "comb_a", 32'({rdy_a, raw_a, waw_a, st_a}), 32'(e.comb_a));
        chk(e.name, "comb_b", 32'({rdy_b, raw_b, waw_b, st_b}), 32'(e.comb_b));
        chk(e.name, "pend_a", pend_a, e.pend_a);
        chk(e.name, "pend_b", pend_b, e.pend_b);
        chk(e.name, "busy_a", 32'(busy_a), 32'(e.busy_a));
        chk(e.name, "busy_b", 32'(busy_b), 32'(e.busy_b));
        chk(e.name, "cnt_a", 32'(cnt_a), e.cnt_a);
        chk(e.name, "cnt_b", 32'(cnt_b), e.cnt_b);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int drain;
    apply(idle());
    #12 nRST = 1'b1;

    drive("reset",       idle(),                                          'b0000, 'b0000, 'h0,    'h0,    'h0, 'h0, 0, 0);
    // RAW on r5, cleared by same-cycle writeback only with bypass
    drive("iss_rd5",     st(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0),          'b1000, 'b1000, 'h0,    'h0,    'h0, 'h0, 0, 0);
    drive("raw5",        st(1, 5, 1, 0, 0, 6, 1, 1, 0, 0, 0, 0),          'b0100, 'b0100, 'h20,   'h20,   'h1, 'h1, 0, 0);
    drive("raw5_wb",     st(1, 5, 1, 0, 0, 6, 1, 1, 'b0001, 'b0001, 5, 0), 'b1000, 'b0100, 'h20,  'h20,   'h1, 'h1, 1, 1);
    drive("after_wb",    idle(),                                          'b0000, 'b0000, 'h40,   'h0,    'h2, 'h0, 1, 2);
    drive("flush1",      fl_only(),                                       'b0000, 'b0000, 'h40,   'h0,    'h2, 'h0, 1, 2);
    drive("flushed1",    idle(),                                          'b0000, 'b0000, 'h0,    'h0,    'h0, 'h0, 1, 2);
    // r0 is never pending
    drive("iss_rd0",     st(1, 0, 1, 0, 0, 0, 1, 2, 0, 0, 0, 0),          'b1000, 'b1000, 'h0,    'h0,    'h0, 'h0, 1, 2);
    drive("rs0_use",     st(1, 0, 1, 0, 1, 0, 1, 3, 0, 0, 0, 0),          'b1000, 'b1000, 'h0,    'h0,    'h4, 'h4, 1, 2);
    drive("flush2",      fl_only(),                                       'b0000, 'b0000, 'h0,    'h0,    'hC, 'hC, 1, 2);
    // Structural hazard on FU1 relieved by same-cycle fu_done
    drive("iss_fu1",     st(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0),          'b1000, 'b1000, 'h0,    'h0,    'h0, 'h0, 1, 2);
    drive("struct1",     st(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0),          'b0001, 'b0001, 'h0,    'h0,    'h2, 'h2, 1, 2);
    drive("struct1_dn",  st(1, 0, 0, 0, 0, 0, 0, 1, 'b0010, 0, 0, 0),     'b1000, 'b0001, 'h0,    'h0,    'h2, 'h2, 2, 3);
    drive("after_dn",    idle(),                                          'b0000, 'b0000, 'h0,    'h0,    'h2, 'h0, 2, 4);
    drive("flush3",      fl_only(),                                       'b0000, 'b0000, 'h0,    'h0,    'h2, 'h0, 2, 4);
    // WAW on r7 with same-cycle writeback from FU2
    drive("iss_rd7",     st(1, 0, 0, 0, 0, 7, 1, 2, 0, 0, 0, 0),          'b1000, 'b1000, 'h0,    'h0,    'h0, 'h0, 2, 4);
    drive("waw7_wb",     st(1, 0, 0, 0, 0, 7, 1, 0, 'b0100, 'b0100, 'h1C00, 0), 'b1000, 'b0010, 'h80, 'h80, 'h4, 'h4, 2, 4);
    drive("after_waw",   idle(),                                          'b0000, 'b0000, 'h80,   'h0,    'h1, 'h0, 2, 5);
    drive("flush4",      fl_only(),                                       'b0000, 'b0000, 'h80,   'h0,    'h1, 'h0, 2, 5);
    // Flush with pending {3,9}, FU0/FU3 busy and a hazard-free issue
    drive("iss_rd3",     st(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0),          'b1000, 'b1000, 'h0,    'h0,    'h0, 'h0, 2, 5);
    drive("iss_rd9",     st(1, 0, 0, 0, 0, 9, 1, 3, 0, 0, 0, 0),          'b1000, 'b1000, 'h8,    'h8,    'h1, 'h1, 2, 5);
    drive("flush_iss",   st(1, 1, 1, 0, 0, 10, 1, 1, 0, 0, 0, 1),         'b0000, 'b0000, 'h208,  'h208,  'h9, 'h9, 2, 5);
    drive("flushed5",    idle(),                                          'b0000, 'b0000, 'h0,    'h0,    'h0, 'h0, 2, 5);
    // Writeback / done to idle state is harmless
    drive("stray_wb",    st(0, 0, 0, 0, 0, 0, 0, 0, 'b1111, 'b0010, 'h80, 0), 'b0000, 'b0000, 'h0, 'h0,   'h0, 'h0, 2, 5);
    drive("after_stray", idle(),                                          'b0000, 'b0000, 'h0,    'h0,    'h0, 'h0, 2, 5);
    // RAW via rs2 only; rs1 match ignored when unused
    drive("iss_rd12",    st(1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 0, 0),         'b1000, 'b1000, 'h0,    'h0,    'h0, 'h0, 2, 5);
    drive("raw12_rs2",   st(1, 12, 0, 12, 1, 0, 0, 1, 0, 0, 0, 0),        'b0100, 'b0100, 'h1000, 'h1000, 'h1, 'h1, 2, 5);
    drive("rs_unused",   st(1, 12, 0, 12, 0, 0, 0, 1, 0, 0, 0, 0),        'b1000, 'b1000, 'h1000, 'h1000, 'h1, 'h1, 3, 6);
    drive("flush6",      fl_only(),                                       'b0000, 'b0000, 'h1000, 'h1000, 'h3, 'h3, 3, 6);
    // Long structural stall: 4-bit counter saturates at 15
    drive("iss_fu1b",    st(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0),          'b1000, 'b1000, 'h0,    'h0,    'h0, 'h0, 3, 6);
    for (int k = 0; k < 20; k++) begin
      drive("sat", st(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 'b0001, 'b0001, 'h0, 'h0, 'h2, 'h2,
            3 + k, (6 + k > 15) ? 15 : 6 + k);
    end
    drive("sat_end",     idle(),                                          'b0000, 'b0000, 'h0,    'h0,    'h2, 'h2, 23, 15);
    // Asynchronous reset mid-run clears everything before the next edge
    @(posedge CLK);
    #1;
    apply(idle());
    nRST = 1'b0;
    push_exp("async_rst", 'b0000, 'b0000, 'h0, 'h0, 'h0, 'h0, 0, 0);
    @(negedge CLK);
    #1 nRST = 1'b1;
    drive("post_rst",    st(1, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0),          'b1000, 'b1000, 'h0,    'h0,    'h0, 'h0, 0, 0);
    drive("post_rst2",   idle(),                                          'b0000, 'b0000, 'h2,    'h2,    'h2, 'h2, 0, 0);

    drain = 0;
    while (q.size() > 0 && drain < 10) begin
      @(posedge CLK);
      drain++;
    end
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
